// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: opcode encodings,
// multiplier FSM states and the flag-packing helper.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD     = 5'b00000;
    localparam opcode_t OP_SUB     = 5'b00001;
    localparam opcode_t OP_AND     = 5'b00010;
    localparam opcode_t OP_OR      = 5'b00011;
    localparam opcode_t OP_XOR     = 5'b00100;
    localparam opcode_t OP_NOP     = 5'b00101;
    localparam opcode_t OP_MUL     = 5'b00110;
    localparam opcode_t OP_BRANCH  = 5'b00111;
    localparam opcode_t OP_IMML    = 5'b01000;
    localparam opcode_t OP_IMMH    = 5'b01001;
    localparam opcode_t OP_LOAD    = 5'b01010;
    localparam opcode_t OP_STORE   = 5'b01011;
    localparam opcode_t OP_DBLOAD  = 5'b01100;
    localparam opcode_t OP_DBSTORE = 5'b01101;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } mul_state_e;

    // Packs a result and its overflow bit into the {N,V,Z} flag vector.
    function automatic logic [2:0] nvz_of(input logic [DATA_W-1:0] res, input logic ovf);
        return {res[DATA_W-1], ovf, (res == {DATA_W{1'b0}})};
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// WIDTH steps per multiply, low WIDTH bits of the product only.
module mul_iter
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] step_sum_s;

    // Accumulator value after the current step (also the final product on the last step).
    assign step_sum_s = acc_q + (mplr_q[0] ? mcand_q : {WIDTH{1'b0}});

    // Next-state logic: capture operands on start, then shift-add until the last step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_MUL_BUSY;
                    cnt_d   = {CNT_W{1'b0}};
                    mcand_d = a;
                    mplr_d  = b;
                    acc_d   = {WIDTH{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL_BUSY: begin
                acc_d   = step_sum_s;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and datapath registers; reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            mcand_q <= {WIDTH{1'b0}};
            mplr_q  <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
        end
    end

    assign busy    = (state_q == ST_MUL_BUSY);
    assign done    = busy && (cnt_q == LAST_STEP);
    assign product = step_sum_s;

endmodule

// File: rtl/execute.sv
// Execute stage: operand forwarding, ALU, address generation, NVZ flags,
// iterative multiply with front-end stall, and the EX/MEM output register.
module execute
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  opcode_t          iOpcode,
    input  logic [WIDTH-1:0] iImm,
    input  logic [3:0]       iSr1,
    input  logic [3:0]       iSr2,
    input  logic [WIDTH-1:0] iData1,
    input  logic [WIDTH-1:0] iData2,
    input  logic             iAlutoReg,
    input  logic             iMemtoReg,
    input  logic             iBustoReg,
    input  logic [3:0]       iWriteBackAddr,
    input  logic             iALUSrc,
    input  logic             iMemRead,
    input  logic             iMemWrite,
    input  logic             iBusWrite,
    input  logic             iWbEn,
    input  logic [3:0]       iWbAddr,
    input  logic [WIDTH-1:0] iWbData,
    output logic [WIDTH-1:0] oResult,
    output logic [WIDTH-1:0] oStoreData,
    output logic             oAlutoReg,
    output logic             oMemtoReg,
    output logic             oBustoReg,
    output logic             oMemRead,
    output logic             oMemWrite,
    output logic             oBusWrite,
    output logic [3:0]       oWriteBackAddr,
    output logic [2:0]       oNVZ,
    output logic             oStall
);

    localparam logic [WIDTH-1:0] LO_BYTE = {{(WIDTH-8){1'b0}}, 8'hFF};
    localparam logic [WIDTH-1:0] HI_BYTE = ~LO_BYTE;
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] store_q, store_d;
    logic             alu_q, alu_d, mem_q, mem_d, bus_q, bus_d;
    logic             mrd_q, mrd_d, mwr_q, mwr_d, bwr_q, bwr_d;
    logic [3:0]       wba_q, wba_d;
    logic [3:0]       mul_dst_q, mul_dst_d;
    logic [2:0]       nvz_q, nvz_d;

    logic [WIDTH-1:0] op_a_s, op_b_s, sum_s, diff_s, mul_product_s;
    logic             ex_fwd_ok_s, add_v_s, sub_v_s, pass_s;
    logic             mul_start_s, mul_busy_s, mul_done_s;
    logic             alusrc_unused_s;

    // ALU-source select is consumed upstream; the immediate arrives pre-positioned.
    assign alusrc_unused_s = iALUSrc;

    // Only a pure ALU result in EX/MEM is a legal forwarding source.
    assign ex_fwd_ok_s = alu_q && !mem_q && !bus_q;

    // Operand A forwarding: EX/MEM first, then MEM/WB, r0 never forwarded.
    always_comb begin
        if (ex_fwd_ok_s && (wba_q == iSr1) && (iSr1 != 4'd0)) begin
            op_a_s = result_q;
        end else if (iWbEn && (iWbAddr == iSr1) && (iSr1 != 4'd0)) begin
            op_a_s = iWbData;
        end else begin
            op_a_s = iData1;
        end
    end

    // Operand B forwarding: same priority as operand A.
    always_comb begin
        if (ex_fwd_ok_s && (wba_q == iSr2) && (iSr2 != 4'd0)) begin
            op_b_s = result_q;
        end else if (iWbEn && (iWbAddr == iSr2) && (iSr2 != 4'd0)) begin
            op_b_s = iWbData;
        end else begin
            op_b_s = iData2;
        end
    end

    assign sum_s   = op_a_s + op_b_s;
    assign diff_s  = op_a_s - op_b_s;
    assign add_v_s = (op_a_s[WIDTH-1] == op_b_s[WIDTH-1]) && (sum_s[WIDTH-1] != op_a_s[WIDTH-1]);
    assign sub_v_s = (op_a_s[WIDTH-1] != op_b_s[WIDTH-1]) && (diff_s[WIDTH-1] != op_a_s[WIDTH-1]);

    assign mul_start_s = (iOpcode == OP_MUL) && !mul_busy_s;

    mul_iter #(.WIDTH(WIDTH)) u_mul_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .a       (op_a_s),
        .b       (op_b_s),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    // Next EX/MEM contents: bubble by default, multiply result on completion, ALU otherwise.
    always_comb begin
        result_d  = ZERO;
        store_d   = ZERO;
        alu_d     = 1'b0;
        mem_d     = 1'b0;
        bus_d     = 1'b0;
        mrd_d     = 1'b0;
        mwr_d     = 1'b0;
        bwr_d     = 1'b0;
        wba_d     = 4'd0;
        nvz_d     = nvz_q;
        mul_dst_d = mul_dst_q;
        pass_s    = 1'b0;
        if (mul_busy_s) begin
            if (mul_done_s) begin
                result_d = mul_product_s;
                alu_d    = 1'b1;
                wba_d    = mul_dst_q;
                nvz_d    = nvz_of(mul_product_s, 1'b0);
            end else begin
                result_d = ZERO;
            end
        end else begin
            case (iOpcode)
                OP_ADD:     begin result_d = sum_s;  pass_s = 1'b1; nvz_d = nvz_of(sum_s, add_v_s); end
                OP_SUB:     begin result_d = diff_s; pass_s = 1'b1; nvz_d = nvz_of(diff_s, sub_v_s); end
                OP_AND:     begin result_d = op_a_s & op_b_s; pass_s = 1'b1; nvz_d = nvz_of(op_a_s & op_b_s, 1'b0); end
                OP_OR:      begin result_d = op_a_s | op_b_s; pass_s = 1'b1; nvz_d = nvz_of(op_a_s | op_b_s, 1'b0); end
                OP_XOR:     begin result_d = op_a_s ^ op_b_s; pass_s = 1'b1; nvz_d = nvz_of(op_a_s ^ op_b_s, 1'b0); end
                OP_IMML:    begin result_d = (op_a_s & HI_BYTE) | iImm; pass_s = 1'b1; end
                OP_IMMH:    begin result_d = (op_a_s & LO_BYTE) | iImm; pass_s = 1'b1; end
                OP_LOAD, OP_STORE, OP_DBLOAD, OP_DBSTORE: begin
                    result_d = op_a_s;
                    pass_s   = 1'b1;
                end
                OP_MUL:     begin mul_dst_d = iWriteBackAddr; end
                default:    begin result_d = ZERO; end
            endcase
            if (pass_s) begin
                store_d = op_b_s;
                alu_d   = iAlutoReg;
                mem_d   = iMemtoReg;
                bus_d   = iBustoReg;
                mrd_d   = iMemRead;
                mwr_d   = iMemWrite;
                bwr_d   = iBusWrite;
                wba_d   = iWriteBackAddr;
            end else begin
                store_d = ZERO;
            end
        end
    end

    // EX/MEM output register and flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= ZERO;
            store_q   <= ZERO;
            alu_q     <= 1'b0;
            mem_q     <= 1'b0;
            bus_q     <= 1'b0;
            mrd_q     <= 1'b0;
            mwr_q     <= 1'b0;
            bwr_q     <= 1'b0;
            wba_q     <= 4'd0;
            mul_dst_q <= 4'd0;
            nvz_q     <= 3'b000;
        end else begin
            result_q  <= result_d;
            store_q   <= store_d;
            alu_q     <= alu_d;
            mem_q     <= mem_d;
            bus_q     <= bus_d;
            mrd_q     <= mrd_d;
            mwr_q     <= mwr_d;
            bwr_q     <= bwr_d;
            wba_q     <= wba_d;
            mul_dst_q <= mul_dst_d;
            nvz_q     <= nvz_d;
        end
    end

    assign oResult        = result_q;
    assign oStoreData     = store_q;
    assign oAlutoReg      = alu_q;
    assign oMemtoReg      = mem_q;
    assign oBustoReg      = bus_q;
    assign oMemRead       = mrd_q;
    assign oMemWrite      = mwr_q;
    assign oBusWrite      = bwr_q;
    assign oWriteBackAddr = wba_q;
    assign oNVZ           = nvz_q;
    assign oStall         = mul_busy_s;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed cases plus randomized
// instruction streams compared against a behavioural model.
module tb_execute;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    opcode_t     iOpcode;
    logic [15:0] iImm, iData1, iData2, iWbData;
    logic [3:0]  iSr1, iSr2, iWriteBackAddr, iWbAddr;
    logic        iAlutoReg, iMemtoReg, iBustoReg, iALUSrc, iMemRead, iMemWrite, iBusWrite, iWbEn;
    logic [15:0] oResult, oStoreData;
    logic        oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite, oStall;
    logic [3:0]  oWriteBackAddr;
    logic [2:0]  oNVZ;

    int n_checks = 0;
    int n_fail   = 0;

    // model of the visible output state
    logic [15:0] m_result, m_store;
    logic        m_alu, m_mem, m_bus, m_mr, m_mw, m_bw, m_stall;
    logic [3:0]  m_wba;
    logic [2:0]  m_nvz;

    execute dut (
        .clk(clk), .rst_n(rst_n), .iOpcode(iOpcode), .iImm(iImm),
        .iSr1(iSr1), .iSr2(iSr2), .iData1(iData1), .iData2(iData2),
        .iAlutoReg(iAlutoReg), .iMemtoReg(iMemtoReg), .iBustoReg(iBustoReg),
        .iWriteBackAddr(iWriteBackAddr), .iALUSrc(iALUSrc), .iMemRead(iMemRead),
        .iMemWrite(iMemWrite), .iBusWrite(iBusWrite), .iWbEn(iWbEn),
        .iWbAddr(iWbAddr), .iWbData(iWbData),
        .oResult(oResult), .oStoreData(oStoreData), .oAlutoReg(oAlutoReg),
        .oMemtoReg(oMemtoReg), .oBustoReg(oBustoReg), .oMemRead(oMemRead),
        .oMemWrite(oMemWrite), .oBusWrite(oBusWrite), .oWriteBackAddr(oWriteBackAddr),
        .oNVZ(oNVZ), .oStall(oStall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".result"}, 32'(oResult), 32'(m_result));
        check_eq({tag, ".store"},  32'(oStoreData), 32'(m_store));
        check_eq({tag, ".ctl"},
                 32'({oAlutoReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite}),
                 32'({m_alu, m_mem, m_bus, m_mr, m_mw, m_bw}));
        check_eq({tag, ".wba"},   32'(oWriteBackAddr), 32'(m_wba));
        check_eq({tag, ".nvz"},   32'(oNVZ), 32'(m_nvz));
        check_eq({tag, ".stall"}, 32'(oStall), 32'(m_stall));
    endtask

    task automatic model_bubble();
        m_result = 16'h0000; m_store = 16'h0000; m_wba = 4'd0;
        m_alu = 1'b0; m_mem = 1'b0; m_bus = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_bw = 1'b0;
    endtask

    task automatic model_reset();
        model_bubble();
        m_nvz = 3'b000; m_stall = 1'b0;
    endtask

    task automatic set_nop();
        iOpcode = OP_NOP; iImm = 16'h0000; iSr1 = 4'd0; iSr2 = 4'd0;
        iData1 = 16'h0000; iData2 = 16'h0000; iWbData = 16'h0000;
        iWriteBackAddr = 4'd0; iWbAddr = 4'd0; iWbEn = 1'b0;
        iAlutoReg = 1'b0; iMemtoReg = 1'b0; iBustoReg = 1'b0; iALUSrc = 1'b0;
        iMemRead = 1'b0; iMemWrite = 1'b0; iBusWrite = 1'b0;
    endtask

    task automatic randomize_inputs();
        iOpcode = 5'($urandom_range(0, 17));
        case (iOpcode)
            OP_IMML: iImm = {8'h00, 8'($urandom)};
            OP_IMMH: iImm = {8'($urandom), 8'h00};
            default: iImm = 16'h0000;
        endcase
        iSr1 = 4'($urandom_range(0, 3)); iSr2 = 4'($urandom_range(0, 3));
        iData1 = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
        iData2 = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
        iWriteBackAddr = 4'($urandom_range(0, 3)); iWbAddr = 4'($urandom_range(0, 3));
        iWbEn = 1'($urandom); iWbData = 16'($urandom);
        iAlutoReg = ($urandom_range(0, 3) != 0); iMemtoReg = ($urandom_range(0, 3) == 0);
        iBustoReg = ($urandom_range(0, 3) == 0); iALUSrc = 1'($urandom);
        iMemRead = 1'($urandom); iMemWrite = 1'($urandom); iBusWrite = 1'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] fwd(input logic [3:0] src, input logic [15:0] rf);
        if (src == 4'd0) return rf;
        if (m_alu && !m_mem && !m_bus && (m_wba == src)) return m_result;
        if (iWbEn && (iWbAddr == src)) return iWbData;
        return rf;
    endfunction

    // Issues the currently driven instruction and checks every following cycle it affects.
    task automatic issue(input string tag);
        logic [15:0] a, b, r;
        logic [31:0] full;
        int          sa, sb, sr;
        logic        pass, upd, v;
        logic [3:0]  dst;
        a = fwd(iSr1, iData1);
        b = fwd(iSr2, iData2);
        sa = int'($signed(a));
        sb = int'($signed(b));
        pass = 1'b1; upd = 1'b0; v = 1'b0; r = 16'h0000; sr = 0;
        case (iOpcode)
            OP_ADD:  begin r = a + b; sr = sa + sb; v = (sr > 32767) || (sr < -32768); upd = 1'b1; end
            OP_SUB:  begin r = a - b; sr = sa - sb; v = (sr > 32767) || (sr < -32768); upd = 1'b1; end
            OP_AND:  begin r = a & b; upd = 1'b1; end
            OP_OR:   begin r = a | b; upd = 1'b1; end
            OP_XOR:  begin r = a ^ b; upd = 1'b1; end
            OP_IMML: r = (a & 16'hFF00) | iImm;
            OP_IMMH: r = (a & 16'h00FF) | iImm;
            OP_LOAD, OP_STORE, OP_DBLOAD, OP_DBSTORE: r = a;
            default: pass = 1'b0;
        endcase
        if (iOpcode == OP_MUL) begin
            full = 32'(a) * 32'(b);
            dst  = iWriteBackAddr;
            tick();
            model_bubble();
            m_stall = 1'b1;
            check_outputs({tag, "/e0"});
            for (int k = 1; k <= 16; k++) begin
                randomize_inputs();
                tick();
                model_bubble();
                if (k < 16) begin
                    m_stall = 1'b1;
                end else begin
                    m_stall  = 1'b0;
                    m_result = full[15:0];
                    m_alu    = 1'b1;
                    m_wba    = dst;
                    m_nvz    = {full[15], 1'b0, (full[15:0] == 16'h0000)};
                end
                check_outputs({tag, "/busy"});
            end
        end else begin
            tick();
            model_bubble();
            if (pass) begin
                m_result = r; m_store = b; m_wba = iWriteBackAddr;
                m_alu = iAlutoReg; m_mem = iMemtoReg; m_bus = iBustoReg;
                m_mr = iMemRead; m_mw = iMemWrite; m_bw = iBusWrite;
            end
            if (upd) m_nvz = {r[15], v, (r == 16'h0000)};
            check_outputs(tag);
        end
    endtask

    initial begin
        set_nop();
        model_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // signed overflow on ADD
        set_nop(); iOpcode = OP_ADD; iSr1 = 4'd1; iSr2 = 4'd2;
        iData1 = 16'h7FFF; iData2 = 16'h0001; iAlutoReg = 1'b1; iWriteBackAddr = 4'd5;
        issue("add_ovf");
        check_eq("add_ovf_res", 32'(oResult), 32'h0000_8000);
        check_eq("add_ovf_nvz", 32'(oNVZ), 32'b110);

        // zero result, then a branch holds the flags
        set_nop(); iOpcode = OP_SUB; iSr1 = 4'd1; iSr2 = 4'd2;
        iData1 = 16'h0005; iData2 = 16'h0005; iAlutoReg = 1'b1; iWriteBackAddr = 4'd5;
        issue("sub_zero");
        check_eq("sub_zero_nvz", 32'(oNVZ), 32'b001);
        set_nop(); iOpcode = OP_BRANCH; iAlutoReg = 1'b1; iWriteBackAddr = 4'd7;
        issue("branch_hold");
        check_eq("branch_hold_nvz", 32'(oNVZ), 32'b001);
        check_eq("branch_ctl", 32'(oAlutoReg), 32'd0);

        // EX/MEM forwarding beats MEM/WB
        set_nop(); iOpcode = OP_ADD; iSr1 = 4'd1; iSr2 = 4'd2;
        iData1 = 16'h0004; iData2 = 16'h0005; iAlutoReg = 1'b1; iWriteBackAddr = 4'd3;
        issue("fwd_add");
        check_eq("fwd_add_res", 32'(oResult), 32'd9);
        set_nop(); iOpcode = OP_XOR; iSr1 = 4'd3; iSr2 = 4'd3;
        iWbEn = 1'b1; iWbAddr = 4'd3; iWbData = 16'h0007; iAlutoReg = 1'b1; iWriteBackAddr = 4'd4;
        issue("fwd_xor");
        check_eq("fwd_xor_res", 32'(oResult), 32'd0);

        // r0 is never forwarded
        set_nop(); iOpcode = OP_ADD; iSr1 = 4'd1; iSr2 = 4'd2;
        iData1 = 16'h0006; iData2 = 16'h0007; iAlutoReg = 1'b1; iWriteBackAddr = 4'd0;
        issue("r0_prod");
        set_nop(); iOpcode = OP_ADD; iSr1 = 4'd0; iSr2 = 4'd0;
        iData1 = 16'h0005; iData2 = 16'h0001; iWbEn = 1'b1; iWbAddr = 4'd0; iWbData = 16'h0063;
        iAlutoReg = 1'b1; iWriteBackAddr = 4'd1;
        issue("r0_use");
        check_eq("r0_res", 32'(oResult), 32'd6);

        // store with MEM/WB-forwarded store data
        set_nop(); issue("nop_gap");
        set_nop(); iOpcode = OP_STORE; iSr1 = 4'd1; iSr2 = 4'd2;
        iData1 = 16'h0040; iData2 = 16'h1111; iWbEn = 1'b1; iWbAddr = 4'd2; iWbData = 16'hBEEF;
        iMemWrite = 1'b1;
        issue("store");
        check_eq("store_addr", 32'(oResult), 32'h0040);
        check_eq("store_data", 32'(oStoreData), 32'hBEEF);
        check_eq("store_mw", 32'(oMemWrite), 32'd1);
        check_eq("store_alu", 32'(oAlutoReg), 32'd0);

        // multiplies
        set_nop(); iOpcode = OP_MUL; iSr1 = 4'd1; iSr2 = 4'd2;
        iData1 = 16'h0102; iData2 = 16'h0003; iWriteBackAddr = 4'd6;
        issue("mul_a");
        check_eq("mul_a_res", 32'(oResult), 32'h0306);
        check_eq("mul_a_alu", 32'(oAlutoReg), 32'd1);
        check_eq("mul_a_nvz", 32'(oNVZ), 32'b000);
        set_nop(); iOpcode = OP_MUL; iSr1 = 4'd1; iSr2 = 4'd2;
        iData1 = 16'h8000; iData2 = 16'h0002; iWriteBackAddr = 4'd7;
        issue("mul_b");
        check_eq("mul_b_res", 32'(oResult), 32'h0000);
        check_eq("mul_b_nvz", 32'(oNVZ), 32'b001);

        // randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            issue("rand");
        end

        // reset in the middle of a multiply
        set_nop(); iOpcode = OP_MUL; iSr1 = 4'd1; iSr2 = 4'd2;
        iData1 = 16'h0003; iData2 = 16'h0005; iWriteBackAddr = 4'd2;
        tick();
        set_nop();
        repeat (8) tick();
        check_eq("mid_mul_stall", 32'(oStall), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_mul_rst");
        @(negedge clk) rst_n = 1'b1;
        set_nop(); iOpcode = OP_ADD; iSr1 = 4'd1; iSr2 = 4'd2;
        iData1 = 16'h0001; iData2 = 16'h0001; iAlutoReg = 1'b1; iWriteBackAddr = 4'd1;
        issue("post_rst_add");
        check_eq("post_rst_res", 32'(oResult), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
